program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Run-control FSM around the single-cycle core. Accepts a request to run one of three programs and loads the program's start PC.
- Gates PC advance and honours datapath stalls. Detects the decoded halt instruction, drains in-flight work and reports completion through a four-phase req/done handshake.
- Also counts cycles per run and enforces a timeout.
- Sits between the testbench/top level and the PC/fetch logic; consumes the instruction decoder's halt indication.

Parameters:
- PC_W, 10, program counter width
- CYC_W, 16, cycle counter width
- PROG0_PC, 0, start address of program 0
- PROG1_PC, 10'h080, start address of program 1
- PROG2_PC, 10'h100, start address of program 2
- DRAIN_CYC, 2, cycles held after halt before done (1..15)
- TIMEOUT, 16'hFFFF, maximum run cycles before forced stop (>= 2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  run request, level, four-phase
- prog_sel  in  2  program index, sampled with req; 3 is invalid
- halt  in  1  decoded halt/done instruction from controller
- stall  in  1  datapath stall (e.g. data memory busy)
- pc_load  out  1  load PC with pc_load_val this cycle
- pc_load_val  out  PC_W  start address of latched program
- pc_en  out  1  PC may advance this cycle
- flush  out  1  clear core pipeline/register-write enables this cycle
- busy  out  1  run in progress (LOAD, RUN, DRAIN)
- done  out  1  run complete, level
- timed_out  out  1  last run ended by timeout
- sel_err  out  1  one-cycle pulse: request with prog_sel==3 rejected
- cycle_count  out  CYC_W  cycles spent in RUN+DRAIN for current/last run
- prog_id  out  2  latched program index

Behaviour:
- Reset applied at an edge, including mid-run: state=IDLE and all outputs 0 from the next cycle; cycle_count=0; prog_id=0; timed_out=0.
- States: IDLE, LOAD, RUN, DRAIN, DONE. All control outputs are Moore, decoded from state.
- IDLE:
  - busy=0, pc_en=0, done=0.
  - req=1 and prog_sel<3: latch prog_id=prog_sel; clear timed_out; go to LOAD.
  - req=1 and prog_sel==3: sel_err=1 for the following cycle only; stay IDLE; prog_id unchanged. A held invalid req re-pulses sel_err every cycle.
- LOAD (exactly one cycle):
  - pc_load=1, flush=1, busy=1, pc_en=0.
  - pc_load_val = PROGn_PC selected by prog_id; 0 in all other states.
  - cycle_count cleared to 0 at the edge leaving LOAD. Next state is RUN.
- Latency: req sampled at edge k puts LOAD in cycle k+1; the PC holds the start address after edge k+2; RUN starts in cycle k+2.
- RUN:
  - busy=1; pc_en=~stall.
  - cycle_count increments every cycle, including stall cycles, and saturates at all-ones.
  - halt=1 and stall=0: load drain counter with DRAIN_CYC; go to DRAIN.
  - halt during stall is ignored until stall drops.
  - cycle_count==TIMEOUT-1 with no qualifying halt: set timed_out=1; go directly to DONE, no drain.
  - Halt and timeout in the same cycle: halt wins and timed_out stays 0.
- DRAIN:
  - busy=1; pc_en=0; halt and stall ignored; cycle_count keeps incrementing.
  - Counter decrements each cycle; go to DONE on the edge where the counter is 1. DRAIN lasts exactly DRAIN_CYC cycles.
- DONE:
  - done=1, busy=0, pc_en=0; cycle_count, prog_id and timed_out held.
  - Leave to IDLE on the first cycle req=0; done drops the cycle after.
- req deassert during LOAD/RUN/DRAIN is ignored; the run completes. A new run needs req low, then high again after done.
- cycle_count, prog_id and timed_out persist through IDLE until the next LOAD.

Test Plan:
- reset held 3 cycles, then req=1, prog_sel=1 at edge 0 -> LOAD in cycle 1 with pc_load=1, pc_load_val=0x080, flush=1; RUN from cycle 2 with pc_en=1.
- RUN for 10 cycles, then halt=1 for one cycle (stall=0), DRAIN_CYC=2 -> pc_en=0 for 2 DRAIN cycles; done=1 after. cycle_count=13; drop req -> done=0 one cycle later; state IDLE.
- stall=1 for 4 cycles in RUN with halt=1 during the stall -> pc_en=0 and no DRAIN entry; halt honoured on the first stall=0 cycle; cycle_count includes the stalled cycles.
- TIMEOUT=20, program never halts -> done=1 and timed_out=1 after exactly 20 RUN cycles; cycle_count=20. Halt and timeout coinciding at cycle 19 -> timed_out=0, DRAIN entered.
- prog_sel=3 with req=1 in IDLE -> sel_err high one cycle per sampled cycle; busy stays 0; no pc_load. Then prog_sel=2 -> pc_load_val=0x100.
- reset asserted in the third DRAIN-less RUN cycle -> next cycle all outputs 0 and cycle_count=0. req still high -> new LOAD on the following cycle.

Source files
------------

// File: rtl/program_sequencer.sv
// Run-control FSM for the single-cycle core: launches one of three programs, gates PC advance,
// drains after halt, enforces a run timeout and reports completion on a four-phase req/done handshake.
module program_sequencer #(
  parameter int              PC_W      = 10,
  parameter int              CYC_W     = 16,
  parameter logic [PC_W-1:0] PROG0_PC  = '0,
  parameter logic [PC_W-1:0] PROG1_PC  = 10'h080,
  parameter logic [PC_W-1:0] PROG2_PC  = 10'h100,
  parameter int              DRAIN_CYC = 2,
  parameter int              TIMEOUT   = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [1:0]       prog_sel,
  input  logic             halt,
  input  logic             stall,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             pc_en,
  output logic             flush,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             sel_err,
  output logic [CYC_W-1:0] cycle_count,
  output logic [1:0]       prog_id
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [3:0]       DRAIN_N  = 4'(DRAIN_CYC);

  state_t     state;
  logic [3:0] dcnt;
  logic       run_q;

  function automatic logic [PC_W-1:0] start_pc(input logic [1:0] sel);
    case (sel)
      2'd0:    start_pc = PROG0_PC;
      2'd1:    start_pc = PROG1_PC;
      default: start_pc = PROG2_PC;
    endcase
  endfunction

  // Stall is the only input allowed straight through: the PC must freeze in the stalled cycle itself.
  assign pc_en = run_q & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dcnt        <= '0;
      run_q       <= 1'b0;
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      flush       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      sel_err     <= 1'b0;
      cycle_count <= '0;
      prog_id     <= '0;
    end else begin
      pc_load     <= 1'b0;
      flush       <= 1'b0;
      pc_load_val <= '0;
      sel_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (prog_sel != 2'd3) begin
              prog_id     <= prog_sel;
              timed_out   <= 1'b0;
              pc_load     <= 1'b1;
              flush       <= 1'b1;
              busy        <= 1'b1;
              pc_load_val <= start_pc(prog_sel);
              state       <= LOAD;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          cycle_count <= '0;
          run_q       <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CYC_W'(1);
          // A qualifying halt takes priority over a coincident timeout.
          if (halt && !stall) begin
            dcnt  <= DRAIN_N;
            run_q <= 1'b0;
            state <= DRAIN;
          end else if (cycle_count == CYC_LAST) begin
            timed_out <= 1'b1;
            run_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DRAIN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CYC_W'(1);
          if (dcnt == 4'd1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            dcnt <= dcnt - 4'd1;
          end
        end
        DONE: begin
          if (!req) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: per-run results are queued when a run is launched and
// compared when done rises; cycle-level control outputs are checked along the way.
module tb_program_sequencer;
  logic        clk = 1'b0;
  logic        reset, req, halt, stall;
  logic [1:0]  prog_sel;
  logic        pc_load, pc_en, flush, busy, done, timed_out, sel_err;
  logic [9:0]  pc_load_val;
  logic [15:0] cycle_count;
  logic [1:0]  prog_id;

  program_sequencer #(
    .PC_W(10), .CYC_W(16), .PROG0_PC(10'h000), .PROG1_PC(10'h080), .PROG2_PC(10'h100),
    .DRAIN_CYC(2), .TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .halt(halt), .stall(stall),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_en(pc_en), .flush(flush), .busy(busy),
    .done(done), .timed_out(timed_out), .sel_err(sel_err), .cycle_count(cycle_count),
    .prog_id(prog_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [1:0] id, input logic [15:0] cnt, input logic to);
    mk = '{id: id, cnt: cnt, to: to};
  endfunction

  function automatic logic [9:0] pc_of(input logic [1:0] sel);
    case (sel)
      2'd0:    pc_of = 10'h000;
      2'd1:    pc_of = 10'h080;
      default: pc_of = 10'h100;
    endcase
  endfunction

  // Issue req, check the LOAD cycle, and stop in the first RUN cycle.
  task automatic start(input logic [1:0] sel);
    prog_sel = sel;
    req      = 1'b1;
    tick();
    chk("load_pc_load", pc_load, 1);
    chk("load_flush", flush, 1);
    chk("load_busy", busy, 1);
    chk("load_pc_en", pc_en, 0);
    chk("load_pc_val", pc_load_val, pc_of(sel));
    chk("load_timed_out", timed_out, 0);
    tick();
    chk("run_pc_en", pc_en, 1);
    chk("run_pc_load", pc_load, 0);
    chk("run_count0", cycle_count, 0);
  endtask

  task automatic wait_done(input int budget, output int n);
    exp_t e;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
    chk("done_busy", busy, 0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("sb_prog_id", prog_id, e.id);
      chk("sb_cycle_count", cycle_count, e.cnt);
      chk("sb_timed_out", timed_out, e.to);
    end
  endtask

  task automatic end_run();
    tick();
    chk("done_held", done, 1);
    req = 1'b0;
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; req = 1'b0; halt = 1'b0; stall = 1'b0; prog_sel = 2'd0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_prog_id", prog_id, 0);
    reset = 1'b0;
    tick();

    // Program 1: 11 RUN cycles (halt on the 11th) + 2 DRAIN cycles.
    sb.push_back(mk(2'd1, 16'd13, 1'b0));
    start(2'd1);
    repeat (10) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("drain1_pc_en", pc_en, 0);
    chk("drain1_busy", busy, 1);
    tick();
    chk("drain2_pc_en", pc_en, 0);
    chk("drain2_done", done, 0);
    tick();
    wait_done(5, n);
    chk("drain_exact", n, 0);
    end_run();

    // Invalid program index is rejected, re-pulsing while held.
    prog_sel = 2'd3;
    req      = 1'b1;
    tick();
    chk("selerr_1", sel_err, 1);
    chk("selerr_busy", busy, 0);
    chk("selerr_pc_load", pc_load, 0);
    tick();
    chk("selerr_2", sel_err, 1);
    chk("selerr_prog_id", prog_id, 1);
    req = 1'b0;
    tick();
    chk("selerr_off", sel_err, 0);

    // Program 2 never halts: timeout after exactly 20 RUN cycles.
    sb.push_back(mk(2'd2, 16'd20, 1'b1));
    start(2'd2);
    wait_done(40, n);
    chk("timeout_cycles", n, 20);
    end_run();
    chk("idle_timed_out_kept", timed_out, 1);

    // Program 0 with a 4-cycle stall carrying halt.
    sb.push_back(mk(2'd0, 16'd9, 1'b0));
    start(2'd0);
    tick();
    tick();
    stall = 1'b1;
    halt  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_pc_en", pc_en, 0);
      chk("stall_busy", busy, 1);
      chk("stall_count", cycle_count, 2 + i);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("unstall_pc_en", pc_en, 1);
    chk("unstall_done", done, 0);
    tick();
    halt = 1'b0;
    chk("stall_drain_pc_en", pc_en, 0);
    chk("stall_drain_busy", busy, 1);
    wait_done(10, n);
    end_run();

    // Halt on the same cycle the timeout would fire: halt wins.
    sb.push_back(mk(2'd1, 16'd22, 1'b0));
    start(2'd1);
    repeat (19) tick();
    chk("coinc_count", cycle_count, 19);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("coinc_busy", busy, 1);
    chk("coinc_timed_out", timed_out, 0);
    wait_done(10, n);
    end_run();

    // Reset in the third RUN cycle, then relaunch with req still high.
    start(2'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_pc_en", pc_en, 0);
    chk("mrst_pc_load", pc_load, 0);
    chk("mrst_count", cycle_count, 0);
    chk("mrst_prog_id", prog_id, 0);
    chk("mrst_done", done, 0);
    sb.push_back(mk(2'd1, 16'd3, 1'b0));
    tick();
    chk("relaunch_pc_load", pc_load, 1);
    chk("relaunch_pc_val", pc_load_val, 10'h080);
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    wait_done(10, n);
    end_run();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
